// File: rtl/flush_sequencer_pkg.sv
// ============================================================================
// Module      : flush_sequencer_pkg
// Description : Shared types and the sequence-number age comparison used by
//               the flush sequencer and ROB-side logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flush_sequencer_pkg;

    localparam int unsigned SQN_W = 6;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned FCNT_W = 32;

    typedef logic [SQN_W-1:0] SqN_t;

    typedef struct packed {
        logic            valid;
        SqN_t            sqN;
        logic [PC_W-1:0] pc;
    } FlushReq_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } flush_state_e;

    // a is older than b when the wrapped difference a-b is negative.
    // Equal sequence numbers are not older.
    function automatic logic sqn_older(input SqN_t a, input SqN_t b);
        SqN_t diff;
        diff = a - b;
        return diff[SQN_W-1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/flush_sequencer_oldest_select.sv
// ============================================================================
// Module      : flush_sequencer_oldest_select
// Description : Combinational NUM_SRC-way oldest-request selector. Picks the
//               valid request with the oldest sqN; ties go to lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flush_sequencer_oldest_select
    import flush_sequencer_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 3,
    localparam int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]       i_req_valid,
    input  logic [NUM_SRC*SQN_W-1:0] i_req_sqn,
    input  logic [NUM_SRC*PC_W-1:0]  i_req_pc,
    output logic                     o_win_valid,
    output logic [IDX_W-1:0]         o_win_idx,
    output logic [SQN_W-1:0]         o_win_sqn,
    output logic [PC_W-1:0]          o_win_pc
);

    FlushReq_t w_req [NUM_SRC];

    // Unpack the flat request buses into per-source records
    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
            assign w_req[g].valid = i_req_valid[g];
            assign w_req[g].sqN   = i_req_sqn[g*SQN_W +: SQN_W];
            assign w_req[g].pc    = i_req_pc[g*PC_W +: PC_W];
        end
    endgenerate

    // Scan from index 0 upward; a later source only replaces the current
    // best when strictly older, so ties stay with the lower index.
    always_comb begin
        o_win_valid = 1'b0;
        o_win_idx   = '0;
        o_win_sqn   = '0;
        o_win_pc    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_req[i].valid && (!o_win_valid || sqn_older(w_req[i].sqN, o_win_sqn))) begin
                o_win_valid = 1'b1;
                o_win_idx   = IDX_W'(i);
                o_win_sqn   = w_req[i].sqN;
                o_win_pc    = w_req[i].pc;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/flush_sequencer.sv
// ============================================================================
// Module      : flush_sequencer
// Description : Arbitrates flush requests, emits a one-cycle invalidate and
//               redirect pulse for the oldest accepted request, and holds a
//               rename-stall recovery window that older requests may preempt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flush_sequencer
    import flush_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 3,
    parameter int unsigned RECOVER_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       IN_reqValid,
    input  logic [NUM_SRC*SQN_W-1:0] IN_reqSqN,
    input  logic [NUM_SRC*PC_W-1:0]  IN_reqPC,
    output logic                     OUT_invalidate,
    output logic [SQN_W-1:0]         OUT_invalidateSqN,
    output logic                     OUT_redirect,
    output logic [PC_W-1:0]          OUT_redirectPC,
    output logic                     OUT_stall,
    output logic [FCNT_W-1:0]        OUT_flushCount
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] C_RECOVER_LOAD = CNT_W'(RECOVER_CYCLES);

    flush_state_e      state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    SqN_t              active_sqn_q, active_sqn_d;
    logic              pulse_q,      pulse_d;
    SqN_t              inv_sqn_q,    inv_sqn_d;
    logic [PC_W-1:0]   redir_pc_q,   redir_pc_d;
    logic [FCNT_W-1:0] flush_count_q, flush_count_d;

    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    SqN_t              win_sqn;
    logic [PC_W-1:0]   win_pc;
    logic              accept;

    flush_sequencer_oldest_select #(
        .NUM_SRC (NUM_SRC)
    ) u_oldest_select (
        .i_req_valid (IN_reqValid),
        .i_req_sqn   (IN_reqSqN),
        .i_req_pc    (IN_reqPC),
        .o_win_valid (win_valid),
        .o_win_idx   (win_idx),
        .o_win_sqn   (win_sqn),
        .o_win_pc    (win_pc)
    );

    // Next-state: accept from IDLE, preempt only with a strictly older
    // request, otherwise count the recovery window down to IDLE.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        active_sqn_d  = active_sqn_q;
        pulse_d       = 1'b0;
        inv_sqn_d     = inv_sqn_q;
        redir_pc_d    = redir_pc_q;
        flush_count_d = flush_count_q;

        accept = win_valid &&
                 ((state_q == ST_IDLE) || sqn_older(win_sqn, active_sqn_q));

        if (accept) begin
            state_d       = ST_RECOVER;
            cnt_d         = C_RECOVER_LOAD;
            active_sqn_d  = win_sqn;
            pulse_d       = 1'b1;
            inv_sqn_d     = win_sqn;
            redir_pc_d    = win_pc;
            flush_count_d = flush_count_q + 32'd1;
        end else if (state_q == ST_RECOVER) begin
            if (cnt_q <= 4'd1) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // State, window and output registers; reset drops any pending pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            active_sqn_q  <= '0;
            pulse_q       <= 1'b0;
            inv_sqn_q     <= '0;
            redir_pc_q    <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            active_sqn_q  <= active_sqn_d;
            pulse_q       <= pulse_d;
            inv_sqn_q     <= inv_sqn_d;
            redir_pc_q    <= redir_pc_d;
            flush_count_q <= flush_count_d;
        end
    end

    // The selector's index must always name the source it reported.
    always_ff @(posedge clk) begin
        if (!rst && win_valid) begin
            assert (IN_reqPC[win_idx*PC_W +: PC_W] == win_pc);
        end
    end

    assign OUT_invalidate    = pulse_q;
    assign OUT_redirect      = pulse_q;
    assign OUT_invalidateSqN = inv_sqn_q;
    assign OUT_redirectPC    = redir_pc_q;
    assign OUT_stall         = (state_q == ST_RECOVER);
    assign OUT_flushCount    = flush_count_q;

endmodule

`default_nettype wire

// File: tb/tb_flush_sequencer.sv
// ============================================================================
// Module      : tb_flush_sequencer
// Description : Self-checking bench for flush_sequencer: directed scenarios
//               and randomized requests against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_flush_sequencer;

    localparam int NUM_SRC = 3;
    localparam int RC      = 4;

    logic                   clk;
    logic                   rst;
    logic [NUM_SRC-1:0]     IN_reqValid;
    logic [NUM_SRC*6-1:0]   IN_reqSqN;
    logic [NUM_SRC*32-1:0]  IN_reqPC;
    logic                   OUT_invalidate;
    logic [5:0]             OUT_invalidateSqN;
    logic                   OUT_redirect;
    logic [31:0]            OUT_redirectPC;
    logic                   OUT_stall;
    logic [31:0]            OUT_flushCount;

    flush_sequencer #(
        .NUM_SRC        (NUM_SRC),
        .RECOVER_CYCLES (RC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .IN_reqValid       (IN_reqValid),
        .IN_reqSqN         (IN_reqSqN),
        .IN_reqPC          (IN_reqPC),
        .OUT_invalidate    (OUT_invalidate),
        .OUT_invalidateSqN (OUT_invalidateSqN),
        .OUT_redirect      (OUT_redirect),
        .OUT_redirectPC    (OUT_redirectPC),
        .OUT_stall         (OUT_stall),
        .OUT_flushCount    (OUT_flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Behavioural model: recovering flag, age of the flush in progress,
    // cycles of stall still owed, and the pulse/count expected next.
    bit          m_rec;
    int          m_active;
    int          m_left;
    bit          m_pulse;
    int          m_psqn;
    logic [31:0] m_ppc;
    logic [31:0] m_count;

    function automatic bit older(input int a, input int b);
        return ((a - b + 64) % 64) >= 32;
    endfunction

    task automatic model_reset();
        m_rec = 0; m_active = 0; m_left = 0; m_pulse = 0;
        m_psqn = 0; m_ppc = '0; m_count = '0;
    endtask

    task automatic model_step(input logic [2:0] v, input int s[3], input logic [31:0] p[3]);
        int best;
        best = -1;
        for (int i = 0; i < NUM_SRC; i++)
            if (v[i] && (best < 0 || older(s[i], s[best]))) best = i;
        m_pulse = 0;
        if (best >= 0 && (!m_rec || older(s[best], m_active))) begin
            m_rec    = 1;
            m_active = s[best];
            m_left   = RC;
            m_pulse  = 1;
            m_psqn   = s[best];
            m_ppc    = p[best];
            m_count  = m_count + 1;
        end else if (m_rec) begin
            m_left--;
            if (m_left == 0) m_rec = 0;
        end
    endtask

    task automatic compare(input string tag);
        check_eq({tag, ".inv"},   OUT_invalidate, m_pulse);
        check_eq({tag, ".redir"}, OUT_redirect,   m_pulse);
        check_eq({tag, ".stall"}, OUT_stall,      m_rec);
        check_eq({tag, ".count"}, OUT_flushCount, m_count);
        if (m_pulse) begin
            check_eq({tag, ".sqn"}, OUT_invalidateSqN, m_psqn[5:0]);
            check_eq({tag, ".pc"},  OUT_redirectPC,    m_ppc);
        end
    endtask

    // One clock: drive at the falling edge, step the model, check after the rise.
    task automatic step(input string tag, input logic [2:0] v,
                        input int s0, input int s1, input int s2,
                        input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
        int          s[3];
        logic [31:0] p[3];
        s[0] = s0; s[1] = s1; s[2] = s2;
        p[0] = p0; p[1] = p1; p[2] = p2;
        @(negedge clk);
        IN_reqValid = v;
        for (int i = 0; i < NUM_SRC; i++) begin
            IN_reqSqN[i*6 +: 6]  = 6'(s[i]);
            IN_reqPC[i*32 +: 32] = p[i];
        end
        model_step(v, s, p);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 3'b000, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        IN_reqValid = '0;
        IN_reqSqN   = '0;
        IN_reqPC    = '0;
        model_reset();
        #1;
        compare("reset");
        repeat (2) @(posedge clk);
        #1;
        compare("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        // Single request
        step("single", 3'b010, 0, 10, 0, 32'h0, 32'h100, 32'h0);
        check_eq("single.cnt_one", OUT_flushCount, 32'd1);
        check_eq("single.sqn10",   OUT_invalidateSqN, 6'd10);
        idle("single_win", 6);

        // Simultaneous: oldest wins, then an exact tie goes to src0
        step("simul", 3'b101, 20, 0, 15, 32'hA000, 32'h0, 32'hC000);
        idle("simul_win", 5);
        step("tie", 3'b101, 15, 0, 15, 32'hA100, 32'h0, 32'hC100);
        check_eq("tie.src0_pc", OUT_redirectPC, 32'hA100);
        idle("tie_win", 5);

        // Younger request during recovery is dropped
        step("rec30", 3'b001, 30, 0, 0, 32'h300, 0, 0);
        idle("rec30_w", 1);
        step("drop31", 3'b001, 31, 0, 0, 32'h310, 0, 0);
        idle("rec30_end", 3);

        // Older request preempts and restarts the window
        step("rec30b", 3'b001, 30, 0, 0, 32'h300, 0, 0);
        idle("rec30b_w", 1);
        step("pre28", 3'b100, 0, 0, 28, 0, 0, 32'h280);
        idle("pre28_win", 5);

        // Wrap-around age comparison
        step("wrap62", 3'b001, 62, 0, 0, 32'h620, 0, 0);
        step("wrap_drop1", 3'b010, 0, 1, 0, 0, 32'h010, 0);
        idle("wrap62_end", 4);
        step("wrap1", 3'b010, 0, 1, 0, 0, 32'h011, 0);
        step("wrap_acc62", 3'b001, 62, 0, 0, 32'h621, 0, 0);
        idle("wrap_end", 5);

        // Asynchronous reset in the middle of recovery
        step("rst_acc", 3'b001, 40, 0, 0, 32'h400, 0, 0);
        idle("rst_w", 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare("rst_mid");
        check_eq("rst_mid.sqn", OUT_invalidateSqN, 6'd0);
        check_eq("rst_mid.pc",  OUT_redirectPC,    32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("after_rst", 3'b010, 0, 10, 0, 0, 32'h100, 0);
        idle("after_rst_w", 5);

        // Randomized requests clustered around a drifting sequence number
        base = int'($urandom_range(0, 63));
        for (int c = 0; c < 400; c++) begin
            logic [2:0] v;
            int s0, s1, s2;
            v  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            s0 = (base + int'($urandom_range(0, 20)) - 10 + 64) % 64;
            s1 = (base + int'($urandom_range(0, 20)) - 10 + 64) % 64;
            s2 = ($urandom_range(0, 3) == 0) ? s0 : (base + int'($urandom_range(0, 20)) - 10 + 64) % 64;
            step("rand", v, s0, s1, s2, $urandom, $urandom, $urandom);
            base = (base + int'($urandom_range(0, 3))) % 64;
        end
        idle("rand_end", 6);

        // Flush counter wraps from all-ones to zero
        @(negedge clk);
        force dut.flush_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.flush_count_q;
        m_count = 32'hFFFF_FFFF;
        #1;
        check_eq("cwrap.preload", OUT_flushCount, 32'hFFFF_FFFF);
        step("cwrap", 3'b001, 5, 0, 0, 32'h500, 0, 0);
        check_eq("cwrap.zero", OUT_flushCount, 32'd0);
        idle("cwrap_w", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/flush_sequencer.md
# flush_sequencer

Arbitrates misprediction and exception flush requests from the execution-side sources and the commit stage. It selects the oldest request by sequence number and drives the reorder buffer's invalidate inputs with a one-cycle pulse. It also drives the frontend redirect, then holds a recovery window during which rename is stalled. It sits between the branch/load-store/commit request sources and the ROB, rename and fetch blocks.

## Interface
- NUM_SRC, 3: number of flush request sources; index 0 has the highest tie priority.
- RECOVER_CYCLES, 4: stall cycles after each accepted flush (1..15).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- IN_reqValid  input  NUM_SRC  per-source flush request.
- IN_reqSqN  input  NUM_SRC*6  sequence number of the offending instruction; flush everything strictly younger.
- IN_reqPC  input  NUM_SRC*32  redirect target per source.
- OUT_invalidate  output  1  one-cycle flush pulse to ROB and queues.
- OUT_invalidateSqN  output  6  sqN accompanying OUT_invalidate.
- OUT_redirect  output  1  one-cycle fetch redirect, coincident with OUT_invalidate.
- OUT_redirectPC  output  32  redirect target.
- OUT_stall  output  1  rename stall; high while recovering.
- OUT_flushCount  output  32  accepted flushes since reset, wrapping.

## Operation
- Age rule: a is older than b iff $signed(a - b) < 0, using a 6-bit difference. Equal sqN counts as not older.
- Each cycle, the winner is the oldest valid request. Ties go to the lowest index.
- States are IDLE and RECOVER. The registers are activeSqN (6b) and cnt (4b).
- IDLE with any request: accept the winner and enter RECOVER.
  - activeSqN and cnt are loaded.
  - cnt = RECOVER_CYCLES.
- IDLE with no request: stay in IDLE.
- In RECOVER, a winner strictly older than activeSqN is accepted. This preempts the current flush and reloads activeSqN and cnt.
- In RECOVER, all other requests are dropped silently. They belong to instructions already flushed.
- In RECOVER with no accepted request, cnt decrements. When cnt reaches 1, return to IDLE.
- Every acceptance (from IDLE or by preemption) does three things:
  - registers OUT_invalidate=1, OUT_redirect=1, OUT_invalidateSqN=winner sqN and OUT_redirectPC=winner PC for the next cycle;
  - increments OUT_flushCount;
  - pulses are registered for that single cycle only.
- OUT_stall = (state == RECOVER).
- Reset values:
  - state IDLE, cnt 0, activeSqN 0;
  - all outputs 0.
- Reset asserted mid-recovery returns the block to IDLE immediately, with no pulse emitted.

## Timing
- Request at edge N leads to OUT_invalidate/OUT_redirect high during cycle N+1, exactly one cycle.
- OUT_stall rises in cycle N+1 and stays high for RECOVER_CYCLES cycles. It falls in cycle N+1+RECOVER_CYCLES unless a preemption occurs.
- A preempting request at cycle M produces a pulse in M+1 and restarts the full window from M+1.
- Back-to-back pulses are legal when successive cycles each bring a strictly older request.
- Simultaneous requests produce a single pulse, for the oldest one.
- A request arriving in the same cycle the window expires is evaluated against activeSqN, since state is still RECOVER.
- The sqN wrap-around comparison must be correct across 63→0.

## Structure
- The shared package holds:
  - the SqN_t typedef (6b);
  - the FlushReq_t struct {valid, sqN, pc};
  - the sqn_older() comparison function, reused by ROB-side logic.
- One natural sub-module: oldest_select, a combinational NUM_SRC-way oldest-request tree that outputs winner valid, index, sqN and pc.
- The FSM and counters live in the top module.

## Test plan
- Single request: src1 sqN=10, PC=0x100 in IDLE.
  - Next cycle: invalidate=1, sqN=10, redirectPC=0x100.
  - stall high for 4 cycles, flushCount=1.
- Simultaneous requests: src0 sqN=20, src2 sqN=15.
  - One pulse with sqN=15.
  - Equal sqN=15 on src0 and src2: src0 wins.
- Recovery with requests:
  - Accept sqN=30. Two cycles later, src0 sqN=31 is dropped (no pulse, stall ends on schedule).
  - sqN=28 then preempts: pulse sqN=28, stall window restarts at 4.
- Wrap-around:
  - Active sqN=62; request sqN=1 is younger and dropped.
  - Active sqN=1; request sqN=62 is older and accepted.
- Reset behaviour:
  - Assert rst during RECOVER with cnt=3: all outputs 0 at once and state IDLE.
  - After release, a new request behaves as in the single-request case.
- Count wrap: preload flushCount=0xFFFFFFFF via forced stimulus; one acceptance gives 0.
